// File: rtl/arb_dds_osel_n.sv
// Registered N-channel output selector for the arbitrary/DDS generator.
// Channel changes are handshaked, optionally sync-aligned, and blanked to midscale.
module arb_dds_osel_n #(
   parameter int unsigned   W         = 16,
   parameter int unsigned   N_CH      = 4,
   parameter int unsigned   SEL_W     = 2,
   parameter int unsigned   BLANK_CYC = 3,
   parameter logic [W-1:0]  MIDSCALE  = {1'b1, {(W-1){1'b0}}}
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic [N_CH*W-1:0] Din,
   input  logic [SEL_W-1:0]  SelReq,
   input  logic              SelLoad,
   input  logic              SyncMode,
   input  logic              Sync,
   output logic [W-1:0]      Dout,
   output logic [SEL_W-1:0]  SelCur,
   output logic              Busy,
   output logic              SelAck,
   output logic              SelErr
);

   localparam logic [1:0] ST_RUN   = 2'd0;
   localparam logic [1:0] ST_WAIT  = 2'd1;
   localparam logic [1:0] ST_BLANK = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [7:0]       cnt_q, cnt_d;
   logic [SEL_W-1:0] pend_q, pend_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic [W-1:0]     dout_q, dout_d;
   logic             ack_q, ack_d;
   logic             err_q, err_d;
   logic [W-1:0]     cur_data, new_data;
   logic             req_bad;

   assign cur_data = Din[sel_q * W +: W];
   assign new_data = Din[pend_q * W +: W];
   assign req_bad  = 32'(SelReq) >= N_CH;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pend_d  = pend_q;
      sel_d   = sel_q;
      dout_d  = cur_data;
      ack_d   = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (SelLoad) begin
               if (req_bad) begin
                  err_d = 1'b1;
               end else if (SelReq == sel_q) begin
                  ack_d = 1'b1;
               end else begin
                  pend_d  = SelReq;
                  cnt_d   = 8'(BLANK_CYC);
                  state_d = SyncMode ? ST_WAIT : ST_BLANK;
               end
            end
         end
         ST_WAIT: begin
            if (Sync) begin
               cnt_d   = 8'(BLANK_CYC);
               state_d = ST_BLANK;
            end
         end
         ST_BLANK: begin
            // Counter holds the number of midscale samples still to be emitted.
            if (cnt_q == 8'd0) begin
               sel_d   = pend_q;
               dout_d  = new_data;
               ack_d   = 1'b1;
               state_d = ST_RUN;
            end else begin
               cnt_d  = cnt_q - 8'd1;
               dout_d = MIDSCALE;
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q <= ST_RUN;
         cnt_q   <= 8'd0;
         pend_q  <= '0;
         sel_q   <= '0;
         dout_q  <= MIDSCALE;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         sel_q   <= sel_d;
         dout_q  <= dout_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
      end
   end

   assign Dout   = dout_q;
   assign SelCur = sel_q;
   assign Busy   = (state_q != ST_RUN);
   assign SelAck = ack_q;
   assign SelErr = err_q;

endmodule
